eprisc_block_copier: RTL and testbench
======================================

# eprisc_block_copier

Bus initiator for the epRISC test memories. On a start strobe it streams a run of 32-bit words out of the synchronous-read ROM and writes them into the synchronous-write RAM, one word per clock. It sits beside the CPU in the testbench and system top as a boot loader / DMA engine, driving the ROM read port and the RAM write port. It also accumulates a 32-bit additive checksum of the copied words.

## Interface
- ADDR_W, 8, word-address width of both memories (256 words)
- DATA_W, 32, word width
- iClk  in  1  sole clock, all state on rising edge
- iReset  in  1  asynchronous, active-high reset
- iStart  in  1  start strobe, sampled on rising edge
- iSrcBase  in  ADDR_W  first ROM word address, latched at start
- iDstBase  in  ADDR_W  first RAM word address, latched at start
- iCount  in  ADDR_W+1  words to copy, 0..256, latched at start
- oBusy  out  1  transfer in progress
- oDone  out  1  one-cycle completion pulse
- oChecksum  out  DATA_W  mod-2^32 sum of words written this transfer
- oRomAddr  out  ADDR_W  ROM read address
- oRomEnable  out  1  ROM output enable
- iRomData  in  DATA_W  ROM data; valid the cycle after its address is presented
- oRamAddr  out  ADDR_W  RAM address
- oRamData  out  DATA_W  RAM write data
- oRamWrite  out  1  RAM write strobe

## Operation
- States: IDLE, RUN, DONE.
- IDLE: iStart=1 at an edge latches src, dst and count, clears oChecksum and the read/write indices, and moves to RUN.
- RUN: issues one ROM read per cycle and performs one RAM write per cycle. Writes trail reads by one cycle.
- RUN exits to DONE after the last write edge. DONE lasts one cycle and returns to IDLE.
- oRamData is combinationally iRomData. oRamWrite and the addresses are registered.
- Address arithmetic is modulo 2^ADDR_W: src+i and dst+i wrap from 0xFF to 0x00.
- Checksum: at each write edge, oChecksum <= oChecksum + oRamData, truncated to 32 bits. It holds its value after DONE until the next accepted start.
- iStart is ignored while in RUN. iStart during the DONE cycle is also ignored. A new start is accepted in IDLE on the cycle after oDone.
- count=0: the block enters RUN for one cycle with no ROM enable and no write, then goes to DONE. oChecksum is 0.
- Reset: asserting iReset forces the state to IDLE and all outputs to 0 immediately (asynchronous), including oRamWrite. A transfer interrupted by reset is abandoned. Words already written stay in RAM. There is no resume.

## Timing
- Cycle n is the interval after edge En. The start is sampled at E0. N is the latched count.
- oBusy=1 in cycles 0..N; it is 0 otherwise.
- oRomEnable=1 in cycles 0..N (N≥1). For N=0 it stays 0.
- oRomAddr=src+n in cycles 0..N-1. In cycle N it holds its last value.
- oRamWrite=1 in cycles 1..N, with oRamAddr=dst+n-1 and oRamData=iRomData (word n-1).
- oDone=1 only in cycle N+1. oBusy=0 in that cycle.
- Latency from start edge to oDone is N+1 cycles. Throughput is one word per clock.
- Reset values: oBusy=0, oDone=0, oChecksum=0, oRomAddr=0, oRomEnable=0, oRamAddr=0, oRamWrite=0. oRamData follows iRomData.

## Test plan
- **Basic copy.** Preload ROM[0..3] = 24413345, 25000000, 26000200, 27010001. Start with src=0x00, dst=0x10, N=4.
  - Required: RAM[0x10..0x13] hold those four words.
  - oRamWrite is high in cycles 1..4 and oDone pulses in cycle 5.
  - oChecksum = 0x96423546.
- **Wrap-around.** Start with src=0xFE, dst=0xFF, N=3.
  - Required: ROM reads from FE, FF, 00.
  - RAM writes go to FF, 00, 01.
- **Zero and full count.** Start with N=0.
  - Required: no ROM enable, no write; oDone in cycle 1; oChecksum=0.
  - Then start with N=256, src=0, dst=0.
  - Required: RAM becomes an exact copy of ROM and oDone appears in cycle 257.
- **Ignored start.** Pulse iStart in cycles 2 and N+1 of an N=8 copy with different bases.
  - Required: the transfer is unaffected and no second transfer begins.
  - A start in cycle N+2 is accepted.
- **Reset mid-transfer.** Assert iReset asynchronously mid-cycle in cycle 3 of an N=8 copy.
  - Required: oRamWrite and oBusy drop without waiting for an edge.
  - Only RAM[dst..dst+1] are written; no oDone appears.
  - A subsequent start runs normally.
- **Back-to-back.** Run N=2 then restart in the first IDLE cycle with new bases.
  - Required: both copies are correct.
  - oChecksum reflects only the second transfer.

Source files
------------

// File: rtl/eprisc_block_copier.sv
// Block copier for the epRISC test memories: streams words from a synchronous-read ROM
// into a RAM at one word per clock and keeps an additive checksum of what was written.
module eprisc_block_copier #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_enable,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_write
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] dst_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   rd_idx;
    logic [ADDR_W:0]   rd_next;

    // ROM data arrives one cycle after its address, which is exactly when it is written.
    assign ram_data = rom_data;
    assign rd_next  = rd_idx + (ADDR_W + 1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dst_reg    <= '0;
            count_reg  <= '0;
            rd_idx     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            checksum   <= '0;
            rom_addr   <= '0;
            rom_enable <= 1'b0;
            ram_addr   <= '0;
            ram_write  <= 1'b0;
        end else begin
            if (ram_write) begin
                checksum <= checksum + rom_data;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        dst_reg    <= dst_base;
                        count_reg  <= count;
                        rd_idx     <= '0;
                        rom_addr   <= src_base;
                        rom_enable <= (count != '0);
                        busy       <= 1'b1;
                        checksum   <= '0;
                    end
                end
                RUN: begin
                    // rd_idx is the read being issued this cycle; its write lands next cycle.
                    if (rd_idx == count_reg) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        rom_enable <= 1'b0;
                        ram_write  <= 1'b0;
                    end else begin
                        rd_idx    <= rd_next;
                        ram_write <= 1'b1;
                        ram_addr  <= dst_reg + rd_idx[ADDR_W-1:0];
                        if (rd_next < count_reg) begin
                            rom_addr <= rom_addr + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eprisc_block_copier.sv
// Directed bench for eprisc_block_copier: behavioural ROM/RAM around the copier, a write
// scoreboard fed at each start, and per-cycle timing checks through every transfer.
module tb_eprisc_block_copier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  src_base = '0;
    logic [7:0]  dst_base = '0;
    logic [8:0]  count = '0;
    logic        busy, done, rom_enable, ram_write;
    logic [31:0] checksum, ram_data;
    logic [7:0]  rom_addr, ram_addr;
    logic [31:0] rom_q = '0;

    logic [31:0] rom_mem [256];
    logic [31:0] ram_mem [256];
    logic [31:0] ram_snap [256];

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    eprisc_block_copier #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_base(src_base), .dst_base(dst_base), .count(count),
        .busy(busy), .done(done), .checksum(checksum),
        .rom_addr(rom_addr), .rom_enable(rom_enable), .rom_data(rom_q),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_write(ram_write)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_enable) rom_q <= rom_mem[rom_addr];
    always @(posedge clk) if (ram_write) ram_mem[ram_addr] <= ram_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every RAM write must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (!rst && ram_write) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("ram_addr", {24'd0, ram_addr}, {24'd0, mon_e.addr});
                check("ram_data", ram_data, mon_e.data);
            end
        end
    end

    task automatic run_copy(input logic [7:0] src, input logic [7:0] dst, input int n,
                            input bit pulses, input int abort_at);
        logic [31:0] sum;
        logic [7:0]  a;
        wr_t         w;
        sum = '0;
        @(negedge clk);
        start = 1'b1; src_base = src; dst_base = dst; count = n[8:0];
        for (int i = 0; i < n; i++) begin
            a = src + 8'(i);
            w.addr = dst + 8'(i);
            w.data = rom_mem[a];
            exp_q.push_back(w);
            sum = sum + rom_mem[a];
        end
        for (int c = 0; c <= n + 1; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == abort_at) begin
                #2 rst = 1'b1;
                #1;
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_ram_write", {31'd0, ram_write}, 32'd0);
                check("rst_rom_enable", {31'd0, rom_enable}, 32'd0);
                check("rst_checksum", checksum, 32'd0);
                exp_q.delete();
                @(negedge clk);
                rst = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("post_rst_done", {31'd0, done}, 32'd0);
                    check("post_rst_busy", {31'd0, busy}, 32'd0);
                end
                return;
            end
            check("busy", {31'd0, busy}, {31'd0, c <= n});
            check("ram_write", {31'd0, ram_write}, {31'd0, (c >= 1 && c <= n)});
            check("done", {31'd0, done}, {31'd0, c == n + 1});
            check("rom_enable", {31'd0, rom_enable}, {31'd0, (n >= 1 && c <= n)});
            if (c < n) begin
                check("rom_addr", {24'd0, rom_addr}, {24'd0, src + 8'(c)});
            end else if (n >= 1 && c == n) begin
                check("rom_addr_hold", {24'd0, rom_addr}, {24'd0, src + 8'(n - 1)});
            end
            if (c <= 1) check("checksum_clear", checksum, 32'd0);
            if (c == n + 1) check("checksum", checksum, sum);
            if (pulses && (c == 2 || c == n + 1)) begin
                start = 1'b1; src_base = src + 8'h40; dst_base = dst + 8'h40; count = 9'd5;
            end
        end
        check("queue_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom_mem[i] = $urandom;
            ram_mem[i] = 32'hA5A5_0000 | i;
        end
        rom_mem[0] = 32'h24413345;
        rom_mem[1] = 32'h25000000;
        rom_mem[2] = 32'h26000200;
        rom_mem[3] = 32'h27010001;

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_checksum", checksum, 32'd0);
        check("reset_rom_addr", {24'd0, rom_addr}, 32'd0);
        check("reset_rom_enable", {31'd0, rom_enable}, 32'd0);
        check("reset_ram_addr", {24'd0, ram_addr}, 32'd0);
        check("reset_ram_write", {31'd0, ram_write}, 32'd0);
        rst = 1'b0;

        // Basic copy
        run_copy(8'h00, 8'h10, 4, 1'b0, -1);
        for (int i = 0; i < 4; i++) check("basic_ram", ram_mem[8'h10 + i], rom_mem[i]);
        check("basic_checksum", checksum, 32'h96423546);

        // Wrap-around
        run_copy(8'hFE, 8'hFF, 3, 1'b0, -1);
        check("wrap_ram_ff", ram_mem[8'hFF], rom_mem[8'hFE]);
        check("wrap_ram_00", ram_mem[8'h00], rom_mem[8'hFF]);
        check("wrap_ram_01", ram_mem[8'h01], rom_mem[8'h00]);

        // Zero and full count
        run_copy(8'h20, 8'h30, 0, 1'b0, -1);
        check("zero_checksum", checksum, 32'd0);
        run_copy(8'h00, 8'h00, 256, 1'b0, -1);
        for (int i = 0; i < 256; i++) check("full_ram", ram_mem[i], rom_mem[i]);

        // Ignored starts, then a start in cycle N+2
        run_copy(8'h50, 8'h60, 8, 1'b1, -1);
        run_copy(8'h70, 8'h80, 3, 1'b0, -1);

        // Reset mid-transfer
        for (int i = 0; i < 256; i++) ram_snap[i] = ram_mem[i];
        for (int i = 0; i < 8; i++) rom_mem[8'h90 + i] = ~ram_mem[8'hA0 + i];
        run_copy(8'h90, 8'hA0, 8, 1'b0, 3);
        check("abort_ram0", ram_mem[8'hA0], rom_mem[8'h90]);
        check("abort_ram1", ram_mem[8'hA1], rom_mem[8'h91]);
        for (int i = 2; i < 8; i++) check("abort_untouched", ram_mem[8'hA0 + i], ram_snap[8'hA0 + i]);
        run_copy(8'h90, 8'hA0, 8, 1'b0, -1);
        for (int i = 0; i < 8; i++) check("after_abort_ram", ram_mem[8'hA0 + i], rom_mem[8'h90 + i]);

        // Back-to-back
        run_copy(8'h10, 8'hC0, 2, 1'b0, -1);
        run_copy(8'h30, 8'hD0, 2, 1'b0, -1);
        check("b2b_ram_c0", ram_mem[8'hC0], rom_mem[8'h10]);
        check("b2b_ram_c1", ram_mem[8'hC1], rom_mem[8'h11]);
        check("b2b_ram_d0", ram_mem[8'hD0], rom_mem[8'h30]);
        check("b2b_ram_d1", ram_mem[8'hD1], rom_mem[8'h31]);
        @(negedge clk);
        check("b2b_checksum_hold", checksum, rom_mem[8'h30] + rom_mem[8'h31]);
        check("idle_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
